// File: rtl/vga_patgen_multi.sv
// Parametrised VGA raster timing and test-pattern generator with a run-time mode select.
// Every output is registered and describes the counter position of the previous DCLK.
module vga_patgen_multi #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int OUT_BITS   = 4,
    parameter int CHK_LOG2   = 5,
    parameter int GRAD_SHIFT = 5
) (
    input  logic                    DCLK,
    input  logic                    RST_X,
    input  logic                    EN,
    input  logic [1:0]              MODE,
    input  logic [3*OUT_BITS-1:0]   SOLID_RGB,
    output logic                    DSP_HSYNC_X,
    output logic                    DSP_VSYNC_X,
    output logic                    DSP_DE,
    output logic [OUT_BITS-1:0]     DSP_R,
    output logic [OUT_BITS-1:0]     DSP_G,
    output logic [OUT_BITS-1:0]     DSP_B,
    output logic                    FRAME_START,
    output logic [1:0]              MODE_Q
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    // Sync end points must stay below the totals, so the back porches are assumed non-zero.
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [VW-1:0]          vcnt_q, vcnt_d;
    logic [2:0]             barIdx_q, barIdx_d;
    logic [BW-1:0]          barPix_q, barPix_d;
    logic [1:0]             mode_q, mode_d;
    logic [3*OUT_BITS-1:0]  solid_q, solid_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   de_q, de_d;
    logic                   frameStart_q, frameStart_d;
    logic [OUT_BITS-1:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic [OUT_BITS-1:0]    pixR, pixG, pixB, grad;
    logic                   active, chk, frameEnd;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!EN) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end else begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    // Bar index tracks hcnt without a divider: restart at column 0, step every BAR_W pixels.
    always_comb begin
        barIdx_d = barIdx_q;
        barPix_d = barPix_q;
        if (hcnt_d == '0) begin
            barIdx_d = '0;
            barPix_d = '0;
        end else if (barPix_q == BAR_LAST) begin
            barPix_d = '0;
            if (barIdx_q != 3'd7) begin
                barIdx_d = barIdx_q + 3'd1;
            end
        end else begin
            barPix_d = barPix_q + 1'b1;
        end
    end

    assign frameEnd = EN && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    assign mode_d   = frameEnd ? MODE : mode_q;
    assign solid_d  = frameEnd ? SOLID_RGB : solid_q;

    assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign grad   = OUT_BITS'(hcnt_q >> GRAD_SHIFT);
    assign chk    = hcnt_q[CHK_LOG2] ^ vcnt_q[CHK_LOG2];

    // Bar colours follow white..black, so each channel is the inverse of one index bit.
    always_comb begin
        pixR = '0;
        pixG = '0;
        pixB = '0;
        case (mode_q)
            2'd0: begin
                pixR = {OUT_BITS{~barIdx_q[1]}};
                pixG = {OUT_BITS{~barIdx_q[2]}};
                pixB = {OUT_BITS{~barIdx_q[0]}};
            end
            2'd1: begin
                pixR = grad;
                pixG = grad;
                pixB = grad;
            end
            2'd2: begin
                pixR = {OUT_BITS{chk}};
                pixG = {OUT_BITS{chk}};
                pixB = {OUT_BITS{chk}};
            end
            default: begin
                pixR = solid_q[3*OUT_BITS-1 -: OUT_BITS];
                pixG = solid_q[2*OUT_BITS-1 -: OUT_BITS];
                pixB = solid_q[OUT_BITS-1:0];
            end
        endcase
    end

    always_comb begin
        hsync_d      = 1'b1;
        vsync_d      = 1'b1;
        de_d         = 1'b0;
        frameStart_d = 1'b0;
        r_d          = '0;
        g_d          = '0;
        b_d          = '0;
        if (EN) begin
            hsync_d      = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
            vsync_d      = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
            de_d         = active;
            frameStart_d = (hcnt_q == '0) && (vcnt_q == '0);
            if (active) begin
                r_d = pixR;
                g_d = pixG;
                b_d = pixB;
            end
        end
    end

    always_ff @(posedge DCLK or negedge RST_X) begin
        if (!RST_X) begin
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            barIdx_q     <= '0;
            barPix_q     <= '0;
            mode_q       <= '0;
            solid_q      <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            de_q         <= 1'b0;
            frameStart_q <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            barIdx_q     <= barIdx_d;
            barPix_q     <= barPix_d;
            mode_q       <= mode_d;
            solid_q      <= solid_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
            frameStart_q <= frameStart_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
        end
    end

    assign DSP_HSYNC_X = hsync_q;
    assign DSP_VSYNC_X = vsync_q;
    assign DSP_DE      = de_q;
    assign DSP_R       = r_q;
    assign DSP_G       = g_q;
    assign DSP_B       = b_q;
    assign FRAME_START = frameStart_q;
    assign MODE_Q      = mode_q;

endmodule

// File: tb/tb_vga_patgen_multi.sv
// Scoreboard bench for vga_patgen_multi on a reduced raster so several frames fit in a short run.
// A reference model pushes the expected output word every DCLK; scenario tasks pop and compare it.
module tb_vga_patgen_multi;

    localparam int H_ACT = 130;
    localparam int H_FP  = 8;
    localparam int H_SY  = 16;
    localparam int H_BP  = 8;
    localparam int V_ACT = 20;
    localparam int V_FP  = 2;
    localparam int V_SY  = 2;
    localparam int V_BP  = 4;
    localparam int OB    = 4;
    localparam int CHK   = 3;
    localparam int GSH   = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int BAR_W = H_ACT / 8;
    localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

    typedef struct {
        logic [17:0] vec;
        int          h;
        int          v;
    } exp_t;

    logic            DCLK;
    logic            RST_X;
    logic            EN;
    logic [1:0]      MODE;
    logic [3*OB-1:0] SOLID_RGB;
    logic            DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, FRAME_START;
    logic [OB-1:0]   DSP_R, DSP_G, DSP_B;
    logic [1:0]      MODE_Q;
    logic [17:0]     dutVec;

    int    checks = 0;
    int    errors = 0;
    exp_t  sbQ[$];
    int    mh, mv;
    logic [1:0]  mMode;
    logic [11:0] mSolid;
    logic        latchNow;

    vga_patgen_multi #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .OUT_BITS(OB), .CHK_LOG2(CHK), .GRAD_SHIFT(GSH)
    ) dut (
        .DCLK(DCLK), .RST_X(RST_X), .EN(EN), .MODE(MODE), .SOLID_RGB(SOLID_RGB),
        .DSP_HSYNC_X(DSP_HSYNC_X), .DSP_VSYNC_X(DSP_VSYNC_X), .DSP_DE(DSP_DE),
        .DSP_R(DSP_R), .DSP_G(DSP_G), .DSP_B(DSP_B),
        .FRAME_START(FRAME_START), .MODE_Q(MODE_Q)
    );

    assign dutVec = {DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, FRAME_START, DSP_R, DSP_G, DSP_B, MODE_Q};

    initial DCLK = 1'b0;
    always #5 DCLK = ~DCLK;

    // Expected output for one counter position; pixel uses the displayed mode, MODE_Q the post-edge mode.
    function automatic exp_t modelOut(int h, int v, logic [1:0] dm, logic [1:0] nm,
                                      logic [11:0] sol, logic en);
        exp_t e;
        logic act, cb;
        logic [2:0] c;
        logic [3:0] r, g, b;
        int bi;
        e.h = h;
        e.v = v;
        r = 4'h0;
        g = 4'h0;
        b = 4'h0;
        act = en && (h < H_ACT) && (v < V_ACT);
        if (act) begin
            case (dm)
                2'd0: begin
                    bi = h / BAR_W;
                    if (bi > 7) bi = 7;
                    c = BAR_RGB[bi[2:0]];
                    r = {4{c[2]}};
                    g = {4{c[1]}};
                    b = {4{c[0]}};
                end
                2'd1: begin
                    r = 4'((h >> GSH) & 15);
                    g = r;
                    b = r;
                end
                2'd2: begin
                    cb = (((h >> CHK) & 1) ^ ((v >> CHK) & 1)) != 0;
                    r = cb ? 4'hF : 4'h0;
                    g = r;
                    b = r;
                end
                default: {r, g, b} = sol;
            endcase
        end
        e.vec = {en ? !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SY) : 1'b1,
                 en ? !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SY) : 1'b1,
                 act, en && h == 0 && v == 0, r, g, b, nm};
        return e;
    endfunction

    assign latchNow = EN && (mh == H_TOT - 1) && (mv == V_TOT - 1);

    always @(posedge DCLK or negedge RST_X) begin
        if (!RST_X) begin
            mh     <= 0;
            mv     <= 0;
            mMode  <= 2'd0;
            mSolid <= 12'h000;
            sbQ.delete();
        end else begin
            sbQ.push_back(modelOut(mh, mv, mMode, latchNow ? MODE : mMode, mSolid, EN));
            if (latchNow) begin
                mMode  <= MODE;
                mSolid <= SOLID_RGB;
            end
            if (!EN) begin
                mh <= 0;
                mv <= 0;
            end else if (mh == H_TOT - 1) begin
                mh <= 0;
                mv <= (mv == V_TOT - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
        end
    end

    task automatic test_reset();
        RST_X = 1'b0;
        EN = 1'b1;
        MODE = 2'd2;
        SOLID_RGB = 12'hFFF;
        repeat (3) begin
            @(negedge DCLK);
            checks++;
            if (dutVec !== 18'h30000) begin
                errors++;
                $display("[TB] FAIL reset_idle: got %h, required %h", dutVec, 18'h30000);
            end
        end
        MODE = 2'd0;
        RST_X = 1'b1;
    endtask

    task automatic test_timing();
        exp_t e;
        logic prevHs = 1'b1, prevVs = 1'b1;
        int hsFirst = -1, hsPrev = -1, hsPeriod = -1, vsFall0 = -1, vsFall1 = -1;
        int hsLow = 0, vsLow = 0, deCnt = 0, fsCnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge DCLK);
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL timing_sb: queue empty, got 0 entries, required 1");
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (dutVec !== e.vec) begin
                    errors++;
                    $display("[TB] FAIL timing_sb h=%0d v=%0d: got %h, required %h", e.h, e.v, dutVec, e.vec);
                end
            end
            if (prevHs && !DSP_HSYNC_X) begin
                if (hsFirst < 0) hsFirst = k;
                if (hsPrev >= 0) hsPeriod = k - hsPrev;
                hsPrev = k;
            end
            if (prevVs && !DSP_VSYNC_X) begin
                if (vsFall0 < 0) vsFall0 = k;
                else vsFall1 = k;
            end
            if (k < FRAME) begin
                if (!DSP_HSYNC_X) hsLow++;
                if (!DSP_VSYNC_X) vsLow++;
                if (DSP_DE) deCnt++;
                if (FRAME_START) fsCnt++;
            end
            prevHs = DSP_HSYNC_X;
            prevVs = DSP_VSYNC_X;
        end
        checks += 7;
        if (hsFirst != H_ACT + H_FP) begin errors++; $display("[TB] FAIL hsync_first_fall: got %0d, required %0d", hsFirst, H_ACT + H_FP); end
        if (hsPeriod != H_TOT) begin errors++; $display("[TB] FAIL hsync_period: got %0d, required %0d", hsPeriod, H_TOT); end
        if (hsLow != H_SY * V_TOT) begin errors++; $display("[TB] FAIL hsync_low: got %0d, required %0d", hsLow, H_SY * V_TOT); end
        if (vsFall1 - vsFall0 != FRAME) begin errors++; $display("[TB] FAIL vsync_period: got %0d, required %0d", vsFall1 - vsFall0, FRAME); end
        if (vsLow != V_SY * H_TOT) begin errors++; $display("[TB] FAIL vsync_low: got %0d, required %0d", vsLow, V_SY * H_TOT); end
        if (deCnt != H_ACT * V_ACT) begin errors++; $display("[TB] FAIL de_count: got %0d, required %0d", deCnt, H_ACT * V_ACT); end
        if (fsCnt != 1) begin errors++; $display("[TB] FAIL frame_start_count: got %0d, required 1", fsCnt); end
    endtask

    task automatic test_bars();
        exp_t e;
        int spots = 0;
        logic [11:0] want;
        for (int k = 0; k < FRAME + H_TOT; k++) begin
            @(negedge DCLK);
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL bars_sb: queue empty, got 0 entries, required 1");
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (dutVec !== e.vec) begin
                    errors++;
                    $display("[TB] FAIL bars_sb h=%0d v=%0d: got %h, required %h", e.h, e.v, dutVec, e.vec);
                end
            end
            if (e.v == 0 && (e.h == 0 || e.h == 15 || e.h == 16 || e.h >= 127) && e.h < H_ACT) begin
                want = (e.h <= 15) ? 12'hFFF : (e.h == 16) ? 12'hFF0 : 12'h000;
                spots++;
                checks++;
                if ({DSP_R, DSP_G, DSP_B} !== want) begin
                    errors++;
                    $display("[TB] FAIL bars_pixel_%0d: got %h, required %h", e.h, {DSP_R, DSP_G, DSP_B}, want);
                end
            end
            if (e.v == 0 && e.h == H_ACT - 1) break;
        end
        checks++;
        if (spots != 6) begin errors++; $display("[TB] FAIL bars_reached: got %0d spots, required 6", spots); end
    endtask

    task automatic test_mode_switch();
        exp_t e;
        logic sawFs = 1'b0;
        int solidPix = 0;
        MODE = 2'd3;
        SOLID_RGB = 12'h5A3;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge DCLK);
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL switch_sb: queue empty, got 0 entries, required 1");
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (dutVec !== e.vec) begin
                    errors++;
                    $display("[TB] FAIL switch_sb h=%0d v=%0d: got %h, required %h", e.h, e.v, dutVec, e.vec);
                end
            end
            if (FRAME_START) sawFs = 1'b1;
            if (!sawFs && e.v == 10 && e.h == 0) begin
                checks++;
                if ({DSP_R, DSP_G, DSP_B, MODE_Q} !== 14'h3FFC) begin
                    errors++;
                    $display("[TB] FAIL switch_old_frame_bars: got %h, required %h", {DSP_R, DSP_G, DSP_B, MODE_Q}, 14'h3FFC);
                end
            end
            if (!sawFs && e.v == V_TOT - 1 && (e.h == H_TOT - 2 || e.h == H_TOT - 1)) begin
                checks++;
                if (MODE_Q !== ((e.h == H_TOT - 1) ? 2'd3 : 2'd0)) begin
                    errors++;
                    $display("[TB] FAIL switch_mode_q_h%0d: got %0d, required %0d", e.h, MODE_Q, (e.h == H_TOT - 1) ? 3 : 0);
                end
            end
            if (sawFs && DSP_DE) begin
                solidPix++;
                checks++;
                if ({DSP_R, DSP_G, DSP_B} !== 12'h5A3) begin
                    errors++;
                    $display("[TB] FAIL switch_solid h=%0d v=%0d: got %h, required 5a3", e.h, e.v, {DSP_R, DSP_G, DSP_B});
                end
            end
            if (sawFs && e.v == V_ACT) break;
        end
        checks++;
        if (solidPix != H_ACT * V_ACT) begin errors++; $display("[TB] FAIL switch_solid_count: got %0d, required %0d", solidPix, H_ACT * V_ACT); end
    endtask

    task automatic test_gradient();
        exp_t e;
        logic sawFs = 1'b0;
        int spots = 0;
        logic [3:0] want;
        MODE = 2'd1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge DCLK);
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL grad_sb: queue empty, got 0 entries, required 1");
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (dutVec !== e.vec) begin
                    errors++;
                    $display("[TB] FAIL grad_sb h=%0d v=%0d: got %h, required %h", e.h, e.v, dutVec, e.vec);
                end
            end
            if (FRAME_START) sawFs = 1'b1;
            if (sawFs && e.v == 0 && (e.h == 3 || e.h == 4 || e.h == 63 || e.h == 64)) begin
                want = (e.h == 3 || e.h == 64) ? 4'h0 : (e.h == 4) ? 4'h1 : 4'hF;
                spots++;
                checks++;
                if ({DSP_R, DSP_G, DSP_B} !== {want, want, want}) begin
                    errors++;
                    $display("[TB] FAIL grad_pixel_%0d: got %h, required %h", e.h, {DSP_R, DSP_G, DSP_B}, {want, want, want});
                end
            end
            if (sawFs && e.v == 0 && e.h == 64) break;
        end
        checks++;
        if (spots != 4) begin errors++; $display("[TB] FAIL grad_reached: got %0d spots, required 4", spots); end
    endtask

    task automatic test_checker();
        exp_t e;
        logic sawFs = 1'b0;
        int spots = 0;
        logic [11:0] want;
        MODE = 2'd2;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge DCLK);
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL chk_sb: queue empty, got 0 entries, required 1");
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (dutVec !== e.vec) begin
                    errors++;
                    $display("[TB] FAIL chk_sb h=%0d v=%0d: got %h, required %h", e.h, e.v, dutVec, e.vec);
                end
            end
            if (FRAME_START) sawFs = 1'b1;
            if (sawFs && (e.h == 0 || e.h == 8) && (e.v == 0 || e.v == 8)) begin
                want = ((e.h == 8) != (e.v == 8)) ? 12'hFFF : 12'h000;
                spots++;
                checks++;
                if ({DSP_R, DSP_G, DSP_B} !== want) begin
                    errors++;
                    $display("[TB] FAIL chk_pixel_%0d_%0d: got %h, required %h", e.h, e.v, {DSP_R, DSP_G, DSP_B}, want);
                end
            end
            if (sawFs && e.v == 8 && e.h == 8) break;
        end
        checks++;
        if (spots != 4) begin errors++; $display("[TB] FAIL chk_reached: got %0d spots, required 4", spots); end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        logic reached = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge DCLK);
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL rstmid_sb: queue empty, got 0 entries, required 1");
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (dutVec !== e.vec) begin
                    errors++;
                    $display("[TB] FAIL rstmid_sb h=%0d v=%0d: got %h, required %h", e.h, e.v, dutVec, e.vec);
                end
            end
            if (e.v == 10 && e.h == 0) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin errors++; $display("[TB] FAIL rstmid_reached: got 0, required 1"); end
        RST_X = 1'b0;
        MODE = 2'd0;
        #1;
        checks++;
        if (dutVec !== 18'h30000) begin errors++; $display("[TB] FAIL rstmid_immediate_idle: got %h, required %h", dutVec, 18'h30000); end
        repeat (3) begin
            @(negedge DCLK);
            checks++;
            if (dutVec !== 18'h30000) begin errors++; $display("[TB] FAIL rstmid_idle: got %h, required %h", dutVec, 18'h30000); end
        end
        RST_X = 1'b1;
        for (int k = 0; k < H_TOT; k++) begin
            @(negedge DCLK);
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL rstmid_post_sb: queue empty, got 0 entries, required 1");
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (dutVec !== e.vec) begin
                    errors++;
                    $display("[TB] FAIL rstmid_post_sb h=%0d v=%0d: got %h, required %h", e.h, e.v, dutVec, e.vec);
                end
            end
            if (k == 0) begin
                checks++;
                if ({FRAME_START, DSP_DE} !== 2'b11) begin
                    errors++;
                    $display("[TB] FAIL rstmid_first_cycle fs/de: got %b, required 11", {FRAME_START, DSP_DE});
                end
            end
        end
    endtask

    task automatic test_en_drop();
        exp_t e;
        logic sawFs = 1'b0, reached = 1'b0;
        MODE = 2'd1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge DCLK);
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL endrop_sb: queue empty, got 0 entries, required 1");
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (dutVec !== e.vec) begin
                    errors++;
                    $display("[TB] FAIL endrop_sb h=%0d v=%0d: got %h, required %h", e.h, e.v, dutVec, e.vec);
                end
            end
            if (FRAME_START) sawFs = 1'b1;
            if (sawFs && e.v == 3 && e.h == 50) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin errors++; $display("[TB] FAIL endrop_reached: got 0, required 1"); end
        EN = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge DCLK);
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL endrop_idle_sb: queue empty, got 0 entries, required 1");
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (dutVec !== e.vec) begin
                    errors++;
                    $display("[TB] FAIL endrop_idle_sb h=%0d v=%0d: got %h, required %h", e.h, e.v, dutVec, e.vec);
                end
            end
            if (k < 10) begin
                checks++;
                if (dutVec !== 18'h30001) begin errors++; $display("[TB] FAIL endrop_idle: got %h, required %h", dutVec, 18'h30001); end
            end else begin
                checks++;
                if ({FRAME_START, DSP_DE} !== 2'b11) begin
                    errors++;
                    $display("[TB] FAIL endrop_restart fs/de: got %b, required 11", {FRAME_START, DSP_DE});
                end
            end
            if (k == 9) EN = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_bars();
        test_mode_switch();
        test_gradient();
        test_checker();
        test_reset_midframe();
        test_en_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
